// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the counter_uni_n codebase slice.
//   cnt_state_t        : two-state counter FSM encoding (CNT_RUN / CNT_HALT)
//   CNT_DEFAULT_WIDTH  : default counter width in bits
package counter_pkg;

  localparam int CNT_DEFAULT_WIDTH = 8;

  typedef enum logic {
    CNT_RUN  = 1'b0,
    CNT_HALT = 1'b1
  } cnt_state_t;

endpackage : counter_pkg

// File: rtl/counter_nextval.sv
// counter_nextval
// Purely combinational next-value arithmetic for counter_uni_n: the bound
// compare, the wrap/stop step value and the preload clamp.
// Ports:
//   i_count     : current registered count
//   i_limit     : inclusive upper bound (range 0..i_limit)
//   i_preld     : raw preload value
//   i_updown    : 1 = count up, 0 = count down
//   i_wrapstop  : 1 = wrap at a bound, 0 = stop (hold) at a bound
//   o_count_step: value after one enabled count in RUN
//   o_boundary  : the enabled count would cross a bound
//   o_load_val  : preload clamped to i_limit
module counter_nextval
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_limit,
  input  logic [WIDTH-1:0] i_preld,
  input  logic             i_updown,
  input  logic             i_wrapstop,
  output logic [WIDTH-1:0] o_count_step,
  output logic             o_boundary,
  output logic [WIDTH-1:0] o_load_val
);

  logic w_at_top;
  logic w_at_bottom;

  // ">=" rather than "==" so a count left above a lowered limit is treated
  // as already sitting on the upper bound.
  assign w_at_top    = (i_count >= i_limit);
  assign w_at_bottom = (i_count == '0);

  assign o_load_val  = (i_preld > i_limit) ? i_limit : i_preld;

  always_comb begin
    o_count_step = i_count;
    o_boundary   = 1'b0;
    if (i_updown) begin
      if (w_at_top) begin
        o_boundary = 1'b1;
        if (i_wrapstop) o_count_step = '0;
      end else begin
        // i_count < i_limit here, so +1 can never carry out of WIDTH bits
        o_count_step = i_count + 1'b1;
      end
    end else begin
      if (w_at_bottom) begin
        o_boundary = 1'b1;
        if (i_wrapstop) o_count_step = i_limit;
      end else begin
        // Decrements normally even when above a lowered limit
        o_count_step = i_count - 1'b1;
      end
    end
  end

endmodule : counter_nextval

// File: rtl/counter_uni_n.sv
// counter_uni_n
// Up/down counter over 0..limit with wrap-or-stop bounds, synchronous
// clear/set/load, and a RUN/HALT FSM (stop mode parks in HALT).
// Optional build macro: CNTR_STICKY_OVF_EN -- overflow becomes sticky
// (cleared only by _areset, _clr or _load); default is a one-cycle pulse.
// Ports:
//   clk        : clock, rising edge
//   _areset    : asynchronous active-low reset
//   _clr       : sync active-low clear to 0 (highest priority)
//   _set       : sync active-low set to limit
//   _load      : sync active-low load of min(preld_val, limit)
//   preld_val  : preload value
//   limit      : inclusive upper bound
//   en         : count enable (active-high)
//   _updown    : 1 = up, 0 = down
//   _wrapstop  : 1 = wrap, 0 = stop at bound
//   dcout      : registered count
//   overflow   : boundary event flag
//   halted     : FSM is in HALT
module counter_uni_n
  import counter_pkg::*;
#(
  parameter int          WIDTH     = CNT_DEFAULT_WIDTH,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             _areset,
  input  logic             _clr,
  input  logic             _set,
  input  logic             _load,
  input  logic [WIDTH-1:0] preld_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  input  logic             _updown,
  input  logic             _wrapstop,
  output logic [WIDTH-1:0] dcout,
  output logic             overflow,
  output logic             halted
);

  localparam logic [WIDTH-1:0] RESET_VAL_W = RESET_VAL[WIDTH-1:0];

  cnt_state_t       r_state;
  cnt_state_t       w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             r_ovf;
  logic             w_ovf_next;
  logic             w_ovf_event;

  logic [WIDTH-1:0] w_count_step;
  logic             w_boundary;
  logic [WIDTH-1:0] w_load_val;

  counter_nextval #(
    .WIDTH (WIDTH)
  ) u_nextval (
    .i_count      (r_count),
    .i_limit      (limit),
    .i_preld      (preld_val),
    .i_updown     (_updown),
    .i_wrapstop   (_wrapstop),
    .o_count_step (w_count_step),
    .o_boundary   (w_boundary),
    .o_load_val   (w_load_val)
  );

  // State / datapath registers
  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      r_state <= CNT_RUN;
      r_count <= RESET_VAL_W;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Next-state and next-count logic
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_ovf_event  = 1'b0;
    if (!_clr) begin
      w_count_next = '0;
      w_state_next = CNT_RUN;
    end else if (!_set) begin
      w_count_next = limit;
      w_state_next = CNT_RUN;
    end else if (!_load) begin
      w_count_next = w_load_val;
      w_state_next = CNT_RUN;
    end else begin
      case (r_state)
        CNT_HALT: begin
          // Exit cycle only; counting resumes on the following edge
          if (_wrapstop) w_state_next = CNT_RUN;
        end
        default: begin
          if (en) begin
            w_count_next = w_count_step;
            w_ovf_event  = w_boundary;
            if (w_boundary && !_wrapstop) w_state_next = CNT_HALT;
          end
        end
      endcase
    end
  end

`ifdef CNTR_STICKY_OVF_EN
  always_comb begin
    w_ovf_next = r_ovf | w_ovf_event;
    if (!_clr || !_load) w_ovf_next = 1'b0;
  end
`else
  always_comb begin
    w_ovf_next = w_ovf_event;
  end
`endif

  // Outputs
  always_comb begin
    dcout    = r_count;
    overflow = r_ovf;
    halted   = (r_state == CNT_HALT);
  end

endmodule : counter_uni_n

// File: tb/tb_counter_uni_n.sv
module tb_counter_uni_n;

  localparam int          W     = 8;
  localparam logic [31:0] RSTV  = 32'd5;

  logic         clk = 1'b0;
  logic         areset_n;
  logic         clr_n, set_n, load_n;
  logic [W-1:0] preld, lim;
  logic         en, updown, wrapstop;
  logic [W-1:0] dcout;
  logic         overflow, halted;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Behavioural model state
  int m_cnt;
  int m_ovf;
  int m_halt;

  always #5 clk = ~clk;

  counter_uni_n #(
    .WIDTH     (W),
    .RESET_VAL (RSTV)
  ) dut (
    .clk       (clk),
    ._areset   (areset_n),
    ._clr      (clr_n),
    ._set      (set_n),
    ._load     (load_n),
    .preld_val (preld),
    .limit     (lim),
    .en        (en),
    ._updown   (updown),
    ._wrapstop (wrapstop),
    .dcout     (dcout),
    .overflow  (overflow),
    .halted    (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit sticky();
`ifdef CNTR_STICKY_OVF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge worth of behaviour, written from the counting rules
  task automatic model_step();
    int l;
    int ev;
    l  = int'(lim);
    ev = 0;
    if (!clr_n) begin
      m_cnt = 0; m_halt = 0;
    end else if (!set_n) begin
      m_cnt = l; m_halt = 0;
    end else if (!load_n) begin
      m_cnt = (int'(preld) < l) ? int'(preld) : l; m_halt = 0;
    end else if (m_halt != 0) begin
      if (wrapstop) m_halt = 0;
    end else if (en) begin
      if (updown) begin
        if (m_cnt < l) m_cnt = m_cnt + 1;
        else begin
          ev = 1;
          if (wrapstop) m_cnt = 0; else m_halt = 1;
        end
      end else begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin
          ev = 1;
          if (wrapstop) m_cnt = l; else m_halt = 1;
        end
      end
    end
    if (sticky()) begin
      if (!clr_n || !load_n) m_ovf = 0;
      else if (ev != 0) m_ovf = 1;
    end else begin
      m_ovf = ev;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".dcout"}, 32'(dcout), m_cnt);
    check_eq({tag, ".ovf"}, 32'(overflow), m_ovf);
    check_eq({tag, ".halted"}, 32'(halted), m_halt);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    $display("cyc=%0d %s clr=%b set=%b ld=%b en=%b ud=%b ws=%b lim=%0d pre=%0d -> dcout=%0d ovf=%b halt=%b",
             cyc, tag, clr_n, set_n, load_n, en, updown, wrapstop, lim, preld, dcout, overflow, halted);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    clr_n = 1; set_n = 1; load_n = 1; en = 0;
  endtask

  // Asynchronous reset pulse placed between edges
  task automatic async_reset(input string tag);
    #2;
    areset_n = 0;
    m_cnt = int'(RSTV[W-1:0]); m_ovf = 0; m_halt = 0;
    #1;
    check_all({tag, ".async"});
    #1;
    areset_n = 1;
  endtask

  initial begin
    areset_n = 0;
    idle_inputs();
    preld = 0; lim = 9; updown = 1; wrapstop = 1;
    m_cnt = int'(RSTV[W-1:0]); m_ovf = 0; m_halt = 0;
    #12;
    check_all("reset");
    check_eq("reset.const", 32'(dcout), 32'd5);
    #4 areset_n = 1;
    #1;

    // Up/wrap over 0..9 from 0
    clr_n = 0; tick("clr");
    clr_n = 1; en = 1;
    for (int i = 1; i <= 11; i++) begin
      tick("upwrap");
      if (i == 10) begin
        check_eq("upwrap.zero", 32'(dcout), 32'd0);
        check_eq("upwrap.pulse", 32'(overflow), 32'd1);
      end
    end
    // Pulse (or sticky) behaviour after the wrap
    en = 0; tick("ovf_after");

    // Down/stop from 2 with limit 200, then exit HALT and wrap to limit
    lim = 200; updown = 0; wrapstop = 0; preld = 2;
    load_n = 0; tick("load2");
    load_n = 1; en = 1;
    repeat (4) tick("downstop");
    check_eq("downstop.halted", 32'(halted), 32'd1);
    wrapstop = 1; tick("halt_exit");
    check_eq("halt_exit.cnt", 32'(dcout), 32'd0);
    tick("wrap_to_lim");
    check_eq("wrap_to_lim.cnt", 32'(dcout), 32'd200);

    // Control priority and load clamp
    clr_n = 0; set_n = 0; load_n = 0; tick("all_low");
    clr_n = 1; preld = 250; lim = 100; tick("set_over_load");
    set_n = 1; tick("load_clamp");
    check_eq("load_clamp.cnt", 32'(dcout), 32'd100);
    load_n = 1;

    // Limit lowered below the count, up direction, wrap then stop
    lim = 200; preld = 50; load_n = 0; en = 0; tick("load50");
    load_n = 1; lim = 20; updown = 1; wrapstop = 1; en = 1; tick("lowlim_wrap");
    lim = 200; load_n = 0; en = 0; tick("load50b");
    load_n = 1; lim = 20; wrapstop = 0; en = 1; tick("lowlim_stop");
    check_eq("lowlim_stop.cnt", 32'(dcout), 32'd50);
    // Down-count above a lowered limit just decrements
    wrapstop = 1; tick("lowlim_exit");
    updown = 0; tick("lowlim_down");

    // limit = 0: every enabled count is a boundary
    lim = 0; clr_n = 0; tick("lim0_clr");
    clr_n = 1;
    repeat (3) begin updown = 1'($urandom); tick("lim0"); end

    // Async reset while counting, resume on first edge after release
    lim = 50; updown = 1; wrapstop = 1; en = 1;
    tick("pre_areset");
    async_reset("mid");
    tick("post_areset");

    // Randomized phase
    for (int i = 0; i < 300; i++) begin
      clr_n    = ($urandom_range(0, 19) != 0);
      set_n    = ($urandom_range(0, 19) != 0);
      load_n   = ($urandom_range(0, 11) != 0);
      en       = ($urandom_range(0, 3) != 0);
      updown   = 1'($urandom);
      wrapstop = ($urandom_range(0, 2) != 0);
      preld    = W'($urandom);
      if ($urandom_range(0, 15) == 0) lim = W'($urandom_range(0, 40));
      tick("rand");
      if ($urandom_range(0, 49) == 0) async_reset("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

endmodule : tb_counter_uni_n
